gshare_trace_driver: RTL and testbench
======================================

Name: gshare_trace_driver

Overview:
- Initiator side of the gshare predictor interface. It replays a branch trace (address plus actual outcome) from a trace memory into the predictor.
- For each entry it presents `addr`, samples `prediction`, then returns the resolved outcome on `branch` with an update strobe.
- It keeps hit, miss and total counters. It is the synthesizable stimulus and scoring end that sits opposite the `Gshare` block in simulation and FPGA bring-up.

Parameters:
- ADDR_W, 11, branch address width; matches the predictor `addr`.
- IDX_W, 16, trace index width; traces hold at most 2^IDX_W entries.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a replay; ignored unless in IDLE.
- trace_len  input  IDX_W  number of entries to replay; sampled at start.
- trace_rd  output  1  trace memory read enable.
- trace_idx  output  IDX_W  trace memory read index.
- trace_data  input  ADDR_W+1  {outcome, address}; valid exactly 1 cycle after trace_rd.
- addr  output  ADDR_W  branch address presented to the predictor.
- prediction  input  1  predictor output (1 = taken); combinational from addr.
- branch  output  1  resolved outcome returned to the predictor.
- upd_valid  output  1  one-cycle strobe; the predictor updates its tables and history on this edge.
- busy  output  1  high from the cycle after start is accepted until DONE.
- done  output  1  one-cycle pulse at the end of a replay.
- n_total, n_hit, n_miss  output  CNT_W each  statistics counters.

Behaviour:
- Reset (reset==0 at an edge):
  - FSM goes to IDLE.
  - Every output is 0: trace_rd, trace_idx, addr, branch, upd_valid, busy, done and all counters.
  - Reset mid-replay aborts immediately; no update strobe is issued afterwards.
- FSM states: IDLE, FETCH, PREDICT, UPDATE, DONE.
- IDLE:
  - On start: latch trace_len, clear all counters, set trace_idx=0.
  - If trace_len==0, go to DONE; otherwise go to FETCH.
- FETCH: trace_rd=1 for this cycle; go to PREDICT.
- PREDICT:
  - trace_data is valid this cycle.
  - Register addr <= trace_data[ADDR_W-1:0] and the outcome bit; go to UPDATE.
  - addr holds that value through UPDATE.
- UPDATE:
  - Sample prediction (with addr stable since the previous edge).
  - Drive branch=outcome and upd_valid=1 for exactly this cycle.
  - Increment n_total. Increment n_hit if prediction==outcome, otherwise n_miss.
  - If trace_idx==latched_len-1, go to DONE. Otherwise increment trace_idx and go to FETCH.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Counters saturate at 2^CNT_W-1 and never wrap. n_hit+n_miss==n_total holds unless saturated. Counters hold their values in IDLE until the next accepted start.
- Throughput: 3 cycles per branch. A replay of N>0 entries has done N*3+2 cycles after the start edge.
- Boundary conditions:
  - start during busy: ignored, with no effect on the latched length.
  - trace_len at its maximum value (2^IDX_W-1): trace_idx never wraps.
  - branch and addr hold their last values outside UPDATE; only upd_valid qualifies them.

Optional Feature:
- Macro: GSHARE_TRACE_STREAK_EN.
- When defined:
  - Adds output `max_miss_streak` [CNT_W-1:0] and an internal current-streak counter.
  - The current streak increments on each miss in UPDATE and resets to 0 on a hit.
  - max_miss_streak updates to max(max, cur+1) on a miss.
  - Both are cleared on reset and on an accepted start, and both saturate.
- When undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package `gshare_pkg`:
  - FSM state encoding constants (IDLE=0, FETCH=1, PREDICT=2, UPDATE=3, DONE=4; 3 bits).
  - Default ADDR_W=11 shared with the predictor.
  - Trace word layout constants: OUTCOME_BIT=ADDR_W.
- One natural sub-module: `sat_counter`, a CNT_W-bit saturating counter with clear and increment. It is instantiated three times (five with streak enabled).

Test Plan:
- Reset mid-replay: assert reset during the 2nd UPDATE of a 4-entry trace. Required: all outputs 0 next edge; upd_valid stays 0 until a new start.
- Zero length: trace_len=0, start. Required: busy never high; done pulses 2 cycles after start; counters all 0.
- Single entry: trace {1, 11'h3A5}, prediction tied to 1. Required: addr=3A5 in UPDATE; branch=1 with one upd_valid pulse; n_total=1, n_hit=1, n_miss=0; done at cycle 5.
- Mixed trace: 6 entries with outcomes 1,1,0,1,0,0, prediction tied to 0. Required: n_total=6, n_hit=3, n_miss=3; exactly 6 upd_valid pulses 3 cycles apart; done at cycle 20.
- Start ignored while busy: second start pulse during PREDICT with trace_len changed 8->2. Required: replay still processes 8 entries; n_total=8.
- Saturation and streak: CNT_W=3, 10 entries all mispredicted, GSHARE_TRACE_STREAK_EN defined. Required: n_miss=7, n_total=7, max_miss_streak=7.

Source files
------------

// File: rtl/gshare_pkg.sv
// Shared constants for the gshare predictor and its trace driver: FSM encoding,
// default address width and trace word layout.
package gshare_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_PREDICT = 3'd2,
    S_UPDATE  = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  localparam int DEF_ADDR_W  = 11;
  localparam int OUTCOME_BIT = DEF_ADDR_W;

endpackage

// File: rtl/gshare_trace_driver_sat_counter.sv
// Saturating counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)                  q_d = '0;
    else if (inc && ~&q_q)    q_d = q_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/gshare_trace_driver.sv
// Replays a {outcome, address} trace into a gshare predictor and scores it.
// Define GSHARE_TRACE_STREAK_EN to add the max_miss_streak output.
module gshare_trace_driver
  import gshare_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int IDX_W  = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  trace_len,
  output logic              trace_rd,
  output logic [IDX_W-1:0]  trace_idx,
  input  logic [ADDR_W:0]   trace_data,
  output logic [ADDR_W-1:0] addr,
  input  logic              prediction,
  output logic              branch,
  output logic              upd_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  n_total,
  output logic [CNT_W-1:0]  n_hit,
  output logic [CNT_W-1:0]  n_miss
`ifdef GSHARE_TRACE_STREAK_EN
  ,
  output logic [CNT_W-1:0]  max_miss_streak
`endif
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    len_q, len_d, idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                branch_q, branch_d;
  logic                trace_rd_q, trace_rd_d;
  logic                upd_valid_q, upd_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                start_acc, do_upd, hit;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    branch_d  = branch_q;
    start_acc = 1'b0;
    do_upd    = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        start_acc = 1'b1;
        len_d     = trace_len;
        idx_d     = '0;
        state_d   = (trace_len == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: state_d = S_PREDICT;
      S_PREDICT: begin
        addr_d   = trace_data[ADDR_W-1:0];
        branch_d = trace_data[ADDR_W];
        state_d  = S_UPDATE;
      end
      S_UPDATE: begin
        do_upd = 1'b1;
        if (idx_q == len_q - IDX_W'(1)) state_d = S_DONE;
        else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Strobes are registered, so they are decoded from the next state; done
    // trails the DONE state by one cycle.
    trace_rd_d  = (state_d == S_FETCH);
    upd_valid_d = (state_d == S_UPDATE);
    busy_d      = (state_d == S_FETCH) || (state_d == S_PREDICT) || (state_d == S_UPDATE);
    done_d      = (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      branch_q    <= 1'b0;
      trace_rd_q  <= 1'b0;
      upd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      branch_q    <= branch_d;
      trace_rd_q  <= trace_rd_d;
      upd_valid_q <= upd_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // branch_q holds the registered outcome throughout UPDATE.
  assign hit = (prediction == branch_q);

  sat_counter #(.W(CNT_W)) u_total (.clk(clk), .reset(reset), .clr(start_acc), .inc(do_upd),         .q(n_total));
  sat_counter #(.W(CNT_W)) u_hit   (.clk(clk), .reset(reset), .clr(start_acc), .inc(do_upd & hit),   .q(n_hit));
  sat_counter #(.W(CNT_W)) u_miss  (.clk(clk), .reset(reset), .clr(start_acc), .inc(do_upd & ~hit),  .q(n_miss));

`ifdef GSHARE_TRACE_STREAK_EN
  logic [CNT_W-1:0] cur_streak;
  // cur never exceeds max, so max(max, cur+1) grows exactly when cur == max.
  sat_counter #(.W(CNT_W)) u_cur (.clk(clk), .reset(reset), .clr(start_acc | (do_upd & hit)),
                                  .inc(do_upd & ~hit), .q(cur_streak));
  sat_counter #(.W(CNT_W)) u_max (.clk(clk), .reset(reset), .clr(start_acc),
                                  .inc(do_upd & ~hit & (cur_streak == max_miss_streak)),
                                  .q(max_miss_streak));
`endif

  assign trace_rd  = trace_rd_q;
  assign trace_idx = idx_q;
  assign addr      = addr_q;
  assign branch    = branch_q;
  assign upd_valid = upd_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_gshare_trace_driver.sv
// Randomized self-checking bench for gshare_trace_driver against a trace-level model.
module tb_gshare_trace_driver;

  localparam int ADDR_W = 11;
  localparam int IDX_W  = 4;
  localparam int CNT_W  = 3;
  localparam int MAXV   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [IDX_W-1:0]  trace_len = '0;
  logic              trace_rd;
  logic [IDX_W-1:0]  trace_idx;
  logic [ADDR_W:0]   trace_data = '0;
  logic [ADDR_W-1:0] addr;
  logic              prediction;
  logic              branch, upd_valid, busy, done;
  logic [CNT_W-1:0]  n_total, n_hit, n_miss;
`ifdef GSHARE_TRACE_STREAK_EN
  logic [CNT_W-1:0]  max_miss_streak;
`endif

  logic [ADDR_W:0]   mem [0:15];
  int                pred_mode = 0;
  logic [ADDR_W-1:0] pred_mask = '0;
  int                n_chk = 0, n_pass = 0;

  gshare_trace_driver #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .trace_len(trace_len),
    .trace_rd(trace_rd), .trace_idx(trace_idx), .trace_data(trace_data),
    .addr(addr), .prediction(prediction), .branch(branch), .upd_valid(upd_valid),
    .busy(busy), .done(done), .n_total(n_total), .n_hit(n_hit), .n_miss(n_miss)
`ifdef GSHARE_TRACE_STREAK_EN
    , .max_miss_streak(max_miss_streak)
`endif
  );

  always #5 clk = ~clk;

  // Trace memory: one-cycle read latency.
  always @(posedge clk) if (trace_rd) trace_data <= mem[trace_idx];

  function automatic logic pred_of(input logic [ADDR_W-1:0] a);
    if (pred_mode == 0) return 1'b0;
    if (pred_mode == 1) return 1'b1;
    return ^(a & pred_mask);
  endfunction

  assign prediction = pred_of(addr);

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  // Scores the first n trace entries from the trace contents alone.
  task automatic model(input int n, output int tot, output int hit, output int miss, output int strk);
    int h = 0, m = 0, cur = 0;
    strk = 0;
    for (int i = 0; i < n; i++) begin
      if (pred_of(mem[i][ADDR_W-1:0]) == mem[i][ADDR_W]) begin h++; cur = 0; end
      else begin m++; cur = sat(cur + 1); if (cur > strk) strk = cur; end
    end
    tot = sat(n); hit = sat(h); miss = sat(m);
  endtask

  task automatic replay(input int n, input int exp_n, input int inj_cyc, input int inj_len);
    int cyc = 0, k = 0, last = 0, busy_seen = 0, tot, hit, miss, strk;
    bit got = 0;
    @(negedge clk); start = 1'b1; trace_len = IDX_W'(n);
    while (cyc < 500 && !got) begin
      @(posedge clk); #1; cyc++;
      if (upd_valid) begin
        if (k < 16) begin
          chk("upd_addr", addr, mem[k][ADDR_W-1:0]);
          chk("upd_branch", branch, mem[k][ADDR_W]);
        end
        if (k > 0) chk("upd_gap", cyc - last, 3);
        last = cyc; k++;
      end
      if (busy) busy_seen = 1;
      if (done) got = 1;
      @(negedge clk);
      start = (cyc == inj_cyc);
      if (start) trace_len = IDX_W'(inj_len);
    end
    chk("done_seen", got, 1);
    chk("done_cyc", cyc, (exp_n == 0) ? 2 : 3 * exp_n + 2);
    chk("n_upd", k, exp_n);
    chk("busy_seen", busy_seen, (exp_n > 0) ? 1 : 0);
    chk("idx_final", trace_idx, (exp_n > 0) ? exp_n - 1 : 0);
    model(exp_n, tot, hit, miss, strk);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("n_total", n_total, tot);
    chk("n_hit", n_hit, hit);
    chk("n_miss", n_miss, miss);
`ifdef GSHARE_TRACE_STREAK_EN
    chk("max_streak", max_miss_streak, strk);
`endif
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 16; i++) mem[i] = (ADDR_W + 1)'($urandom);
  endtask

  initial begin
    int cyc, bad;
    rand_mem();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {trace_rd, trace_idx, addr, branch, upd_valid, busy, done}, 0);
    chk("rst_cnt", {n_total, n_hit, n_miss}, 0);
    @(negedge clk); reset = 1'b1;

    // Zero length
    replay(0, 0, -1, 0);

    // Single entry, always-taken predictor
    mem[0] = {1'b1, 11'h3A5}; pred_mode = 1;
    replay(1, 1, -1, 0);

    // Mixed outcomes, never-taken predictor
    rand_mem(); pred_mode = 0;
    foreach (mem[i]) if (i < 6) mem[i][ADDR_W] = (i == 0 || i == 1 || i == 3);
    replay(6, 6, -1, 0);

    // Second start during PREDICT with a shorter length is ignored
    rand_mem(); pred_mode = 2; pred_mask = ADDR_W'($urandom);
    replay(8, 8, 2, 2);

    // Maximum length: index must stop at 14 without wrapping
    rand_mem(); pred_mask = ADDR_W'($urandom);
    replay(15, 15, -1, 0);

    // All mispredicted: counters and streak saturate
    rand_mem(); pred_mode = 1;
    for (int i = 0; i < 16; i++) mem[i][ADDR_W] = 1'b0;
    replay(10, 10, -1, 0);

    // Random trials
    for (int t = 0; t < 4; t++) begin
      int n;
      rand_mem();
      pred_mode = $urandom_range(0, 2); pred_mask = ADDR_W'($urandom);
      n = $urandom_range(1, 15);
      replay(n, n, -1, 0);
    end

    // Reset during 2nd UPDATE of a 4-entry trace
    rand_mem(); pred_mode = 2;
    @(negedge clk); start = 1'b1; trace_len = 4'd4;
    cyc = 0;
    repeat (6) begin
      @(posedge clk); #1; cyc++;
      @(negedge clk); start = 1'b0;
    end
    chk("mid_upd", upd_valid, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_outs", {trace_rd, trace_idx, addr, branch, upd_valid, busy, done}, 0);
    chk("mid_rst_cnt", {n_total, n_hit, n_miss}, 0);
    @(negedge clk); reset = 1'b1;
    bad = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (upd_valid || busy || done) bad++;
    end
    chk("post_rst_quiet", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
